// File: rtl/sodor2_core.sv
// Two-stage (fetch / execute) in-order RV32I integer core without CSRs.
// Latency: one instruction per cycle; a taken control transfer costs one bubble.
// Backpressure: a memory op in X stalls F and X until io_dmem_resp_valid; an imem miss inserts a bubble.
//
// Ports:
//   clock, reset                 core clock; asynchronous active-low reset
//   io_imem_req_* / io_imem_resp_* instruction fetch request (PC_F) and returned instruction
//   io_dmem_req_* / io_dmem_resp_* data request (addr/data/fcn/typ) and completion/load data
//   io_reset_vector              boot PC, sampled on the first clock after reset release
//   io_hartid, io_interrupt_*    inert, except io_interrupt_debug when
//                                SODOR2_CORE_DEBUG_HALT_EN is defined (halts fetch)
module sodor2_core #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clock,
  input  logic            reset,
  output logic            io_imem_req_valid,
  output logic [XLEN-1:0] io_imem_req_bits_addr,
  input  logic            io_imem_resp_valid,
  input  logic [31:0]     io_imem_resp_bits_data,
  output logic            io_dmem_req_valid,
  output logic [XLEN-1:0] io_dmem_req_bits_addr,
  output logic [XLEN-1:0] io_dmem_req_bits_data,
  output logic            io_dmem_req_bits_fcn,
  output logic [2:0]      io_dmem_req_bits_typ,
  input  logic            io_dmem_resp_valid,
  input  logic [XLEN-1:0] io_dmem_resp_bits_data,
  input  logic            io_hartid,
  input  logic            io_interrupt_debug,
  input  logic            io_interrupt_meip,
  input  logic            io_interrupt_msip,
  input  logic            io_interrupt_mtip,
  input  logic [XLEN-1:0] io_reset_vector
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic            started;
  logic [XLEN-1:0] pc_f;
  logic            x_valid;
  logic [31:0]     x_inst;
  logic [XLEN-1:0] x_pc;
  logic [XLEN-1:0] rf [NUM_REGS];

  logic halt;
  logic unused;
  assign unused = ^{io_hartid, io_interrupt_debug, io_interrupt_meip,
                    io_interrupt_msip, io_interrupt_mtip};
`ifdef SODOR2_CORE_DEBUG_HALT_EN
  assign halt = io_interrupt_debug;
`else
  assign halt = 1'b0;
`endif

  // Decode fields and immediates
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode  = x_inst[6:0];
  assign funct3  = x_inst[14:12];
  assign rd      = x_inst[11:7];
  assign rs1     = x_inst[19:15];
  assign rs2     = x_inst[24:20];
  assign rs1_val = rf[rs1];
  assign rs2_val = rf[rs2];
  assign imm_i   = {{20{x_inst[31]}}, x_inst[31:20]};
  assign imm_s   = {{20{x_inst[31]}}, x_inst[31:25], x_inst[11:7]};
  assign imm_b   = {{19{x_inst[31]}}, x_inst[31], x_inst[7], x_inst[30:25], x_inst[11:8], 1'b0};
  assign imm_u   = {x_inst[31:12], 12'b0};
  assign imm_j   = {{11{x_inst[31]}}, x_inst[31], x_inst[19:12], x_inst[20], x_inst[30:21], 1'b0};

  // ALU shared by OP and OP-IMM; bit 30 selects SUB (OP only) and SRA/SRAI
  logic [XLEN-1:0] alu_b, alu_out;
  logic [4:0]      shamt;
  assign alu_b = (opcode == OP_REG) ? rs2_val : imm_i;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_out = '0;
    case (funct3)
      3'd0: alu_out = (opcode == OP_REG && x_inst[30]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'd1: alu_out = rs1_val << shamt;
      3'd2: alu_out = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'd3: alu_out = {31'b0, rs1_val < alu_b};
      3'd4: alu_out = rs1_val ^ alu_b;
      3'd5: alu_out = x_inst[30] ? XLEN'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'd6: alu_out = rs1_val | alu_b;
      default: alu_out = rs1_val & alu_b;
    endcase
  end

  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'd0: br_taken = (rs1_val == rs2_val);
      3'd1: br_taken = (rs1_val != rs2_val);
      3'd4: br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'd5: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6: br_taken = (rs1_val < rs2_val);
      3'd7: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  logic [XLEN-1:0] load_val;
  always_comb begin
    case (funct3)
      3'd0: load_val = {{24{io_dmem_resp_bits_data[7]}}, io_dmem_resp_bits_data[7:0]};
      3'd1: load_val = {{16{io_dmem_resp_bits_data[15]}}, io_dmem_resp_bits_data[15:0]};
      3'd4: load_val = {24'b0, io_dmem_resp_bits_data[7:0]};
      3'd5: load_val = {16'b0, io_dmem_resp_bits_data[15:0]};
      default: load_val = io_dmem_resp_bits_data;
    endcase
  end

  // Per-opcode control; unsupported opcodes and funct3 encodings fall through as NOPs
  logic            wb_en, redirect, is_load, is_store;
  logic [XLEN-1:0] wb_data, target;
  always_comb begin
    wb_en    = 1'b0;
    wb_data  = '0;
    redirect = 1'b0;
    target   = '0;
    is_load  = 1'b0;
    is_store = 1'b0;
    case (opcode)
      OP_LUI:   begin wb_en = 1'b1; wb_data = imm_u; end
      OP_AUIPC: begin wb_en = 1'b1; wb_data = x_pc + imm_u; end
      OP_JAL: begin
        wb_en = 1'b1; wb_data = x_pc + 32'd4;
        redirect = 1'b1; target = x_pc + imm_j;
      end
      OP_JALR: begin
        wb_en = 1'b1; wb_data = x_pc + 32'd4;
        redirect = 1'b1; target = (rs1_val + imm_i) & ~32'd1;
      end
      OP_BRANCH: begin redirect = br_taken; target = x_pc + imm_b; end
      OP_LOAD: begin
        is_load = (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        wb_en = is_load; wb_data = load_val;
      end
      OP_STORE: is_store = (funct3 inside {3'd0, 3'd1, 3'd2});
      OP_IMM, OP_REG: begin wb_en = 1'b1; wb_data = alu_out; end
      default: ;
    endcase
  end

  logic mem_op, stall, do_redirect, do_wb;
  assign mem_op      = x_valid && (is_load || is_store);
  assign stall       = mem_op && !io_dmem_resp_valid;
  assign do_redirect = x_valid && redirect;
  assign do_wb       = x_valid && !stall && wb_en && (rd != 5'd0);

  assign io_imem_req_valid     = started;
  assign io_imem_req_bits_addr = pc_f;
  assign io_dmem_req_valid     = mem_op;
  assign io_dmem_req_bits_addr = mem_op ? rs1_val + (is_store ? imm_s : imm_i) : '0;
  assign io_dmem_req_bits_data = (mem_op && is_store) ? rs2_val : '0;
  assign io_dmem_req_bits_fcn  = mem_op && is_store;
  assign io_dmem_req_bits_typ  = mem_op ? funct3 + 3'd1 : 3'd0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      started <= 1'b0;
      pc_f    <= '0;
      x_valid <= 1'b0;
      x_inst  <= '0;
      x_pc    <= '0;
    end else if (!started) begin
      started <= 1'b1;
      pc_f    <= io_reset_vector;
    end else if (stall) begin
      // hold F and X so the memory request stays stable
    end else if (do_redirect) begin
      pc_f    <= target;
      x_valid <= 1'b0;
    end else if (halt || !io_imem_resp_valid) begin
      x_valid <= 1'b0;
    end else begin
      x_valid <= 1'b1;
      x_inst  <= io_imem_resp_bits_data;
      x_pc    <= pc_f;
      pc_f    <= pc_f + 32'd4;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (do_wb) begin
      rf[rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_sodor2_core.sv
// Directed bench for sodor2_core: runs a small program from a local imem and
// observes register state through stores on the data port.
module tb_sodor2_core;
  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dmem_req_valid;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_data;
  logic        dmem_req_fcn;
  logic [2:0]  dmem_req_typ;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        hartid, dbg, meip, msip, mtip;
  logic [31:0] reset_vector;

  logic [31:0] imem [0:255];
  assign imem_resp_data = imem[imem_req_addr[9:2]];

  int checks = 0;
  int failures = 0;

  sodor2_core dut (
    .clock(clock), .reset(reset),
    .io_imem_req_valid(imem_req_valid), .io_imem_req_bits_addr(imem_req_addr),
    .io_imem_resp_valid(imem_resp_valid), .io_imem_resp_bits_data(imem_resp_data),
    .io_dmem_req_valid(dmem_req_valid), .io_dmem_req_bits_addr(dmem_req_addr),
    .io_dmem_req_bits_data(dmem_req_data), .io_dmem_req_bits_fcn(dmem_req_fcn),
    .io_dmem_req_bits_typ(dmem_req_typ), .io_dmem_resp_valid(dmem_resp_valid),
    .io_dmem_resp_bits_data(dmem_resp_data), .io_hartid(hartid),
    .io_interrupt_debug(dbg), .io_interrupt_meip(meip), .io_interrupt_msip(msip),
    .io_interrupt_mtip(mtip), .io_reset_vector(reset_vector)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait (bounded) for a store to reach X, check it, then let it complete.
  task automatic expect_store(input string tag, input logic [31:0] addr, input logic [31:0] data);
    for (int n = 0; n < 20 && !dmem_req_valid; n++) tick();
    check({tag, "_vld"}, 32'(dmem_req_valid), 32'd1);
    check({tag, "_addr"}, dmem_req_addr, addr);
    check({tag, "_data"}, dmem_req_data, data);
    check({tag, "_fcn"}, 32'(dmem_req_fcn), 32'd1);
    check({tag, "_typ"}, 32'(dmem_req_typ), 32'd3);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    imem[32'h108 >> 2] = 32'h0020_0313; // addi x6,x0,2
    imem[32'h10C >> 2] = 32'h0060_2023; // sw   x6,0(x0)
    imem[32'h110 >> 2] = 32'h0050_0093; // addi x1,x0,5
    imem[32'h114 >> 2] = 32'h0050_0113; // addi x2,x0,5
    imem[32'h118 >> 2] = 32'h0E80_02EF; // jal  x5,0x200
    imem[32'h200 >> 2] = 32'h0020_8863; // beq  x1,x2,+16
    imem[32'h204 >> 2] = 32'h0010_0393; // addi x7,x0,1 (must be squashed)
    imem[32'h210 >> 2] = 32'h0070_2223; // sw   x7,4(x0)
    imem[32'h214 >> 2] = 32'h0050_2423; // sw   x5,8(x0)
    imem[32'h218 >> 2] = 32'h0000_0403; // lb   x8,0(x0)
    imem[32'h21C >> 2] = 32'h0000_4483; // lbu  x9,0(x0)
    imem[32'h220 >> 2] = 32'h0080_2623; // sw   x8,12(x0)
    imem[32'h224 >> 2] = 32'h0090_2823; // sw   x9,16(x0)
    imem[32'h228 >> 2] = 32'h4010_0533; // sub  x10,x0,x1
    imem[32'h22C >> 2] = 32'h00A0_B5B3; // sltu x11,x1,x10
    imem[32'h230 >> 2] = 32'h00A0_A633; // slt  x12,x1,x10
    imem[32'h234 >> 2] = 32'h1234_56B7; // lui  x13,0x12345
    imem[32'h238 >> 2] = 32'h4015_5713; // srai x14,x10,1
    imem[32'h23C >> 2] = 32'h00A0_2A23; // sw   x10,20(x0)
    imem[32'h240 >> 2] = 32'h00B0_2C23; // sw   x11,24(x0)
    imem[32'h244 >> 2] = 32'h00C0_2E23; // sw   x12,28(x0)
    imem[32'h248 >> 2] = 32'h02D0_2023; // sw   x13,32(x0)
    imem[32'h24C >> 2] = 32'h02E0_2223; // sw   x14,36(x0)
    imem[32'h250 >> 2] = 32'h0060_2023; // sw   x6,0(x0)

    reset = 1'b0; imem_resp_valid = 1'b1; dmem_resp_valid = 1'b1; dmem_resp_data = '0;
    hartid = 1'b0; dbg = 1'b0; meip = 1'b0; msip = 1'b0; mtip = 1'b0;
    reset_vector = 32'h0000_0100;
    repeat (3) tick();
    check("rst_imem_vld", 32'(imem_req_valid), 32'd0);
    check("rst_dmem_vld", 32'(dmem_req_valid), 32'd0);
    check("rst_dmem_typ", 32'(dmem_req_typ), 32'd0);

    // Boot sequence
    reset = 1'b1;
    tick();
    check("boot_vld", 32'(imem_req_valid), 32'd1);
    check("boot_pc0", imem_req_addr, 32'h100);
    tick(); check("boot_pc1", imem_req_addr, 32'h104);
    tick(); check("boot_pc2", imem_req_addr, 32'h108);
    check("boot_dmem", 32'(dmem_req_valid), 32'd0);

    // addi then stalled sw
    dmem_resp_valid = 1'b0;
    tick(); tick();
    check("sw_vld", 32'(dmem_req_valid), 32'd1);
    check("sw_fcn", 32'(dmem_req_fcn), 32'd1);
    check("sw_typ", 32'(dmem_req_typ), 32'd3);
    check("sw_addr", dmem_req_addr, 32'h0);
    check("sw_data", dmem_req_data, 32'h2);
    tick();
    check("sw_stall_pc", imem_req_addr, 32'h110);
    check("sw_stall_data", dmem_req_data, 32'h2);
    dmem_resp_valid = 1'b1;
    tick();
    check("sw_done_vld", 32'(dmem_req_valid), 32'd0);
    check("sw_done_pc", imem_req_addr, 32'h114);

    // Fetch bubbles
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bubble_pc", imem_req_addr, 32'h114);
      check("bubble_dmem", 32'(dmem_req_valid), 32'd0);
    end
    imem_resp_valid = 1'b1;

    // jal and taken beq
    tick(); tick(); tick();
    check("jal_target", imem_req_addr, 32'h200);
    tick(); check("beq_fetch", imem_req_addr, 32'h204);
    tick(); check("beq_target", imem_req_addr, 32'h210);
    expect_store("squash_x7", 32'd4, 32'h0);
    expect_store("jal_link", 32'd8, 32'h11C);

    // lb with two stall cycles, then lbu
    dmem_resp_valid = 1'b0;
    check("lb_vld", 32'(dmem_req_valid), 32'd1);
    check("lb_fcn", 32'(dmem_req_fcn), 32'd0);
    check("lb_typ", 32'(dmem_req_typ), 32'd1);
    check("lb_pc", imem_req_addr, 32'h21C);
    tick(); check("lb_stall1_pc", imem_req_addr, 32'h21C);
    tick(); check("lb_stall2_pc", imem_req_addr, 32'h21C);
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'h0000_0080;
    tick();
    check("lbu_typ", 32'(dmem_req_typ), 32'd5);
    check("lbu_pc", imem_req_addr, 32'h220);
    tick();
    expect_store("lb_sext", 32'd12, 32'hFFFF_FF80);
    expect_store("lbu_zext", 32'd16, 32'h0000_0080);
    expect_store("sub", 32'd20, 32'hFFFF_FFFB);
    expect_store("sltu", 32'd24, 32'h1);
    expect_store("slt", 32'd28, 32'h0);
    expect_store("lui", 32'd32, 32'h1234_5000);
    expect_store("srai", 32'd36, 32'hFFFF_FFFD);

    // Reset during a pending store
    dmem_resp_valid = 1'b0;
    for (int n = 0; n < 20 && !dmem_req_valid; n++) tick();
    check("pend_vld", 32'(dmem_req_valid), 32'd1);
    check("pend_data", dmem_req_data, 32'h2);
    tick();
    reset = 1'b0;
    #1;
    check("midrst_dmem", 32'(dmem_req_valid), 32'd0);
    check("midrst_imem", 32'(imem_req_valid), 32'd0);
    reset_vector = 32'h0000_010C;
    dmem_resp_valid = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("reboot_pc", imem_req_addr, 32'h10C);
    expect_store("reboot_rf", 32'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sodor2_core.md
Name: sodor2_core

Overview:
- Two-stage in-order RV32I integer core: Fetch (F) and Execute (X).
- F holds the PC and drives the instruction memory request.
- X decodes, reads the register file, executes, accesses data memory and writes back in one stage.
- Sits between the instruction and data memory ports of the tile. It has no CSRs; interrupt and hartid inputs are inert unless the optional feature is enabled.

Parameters:
- XLEN, 32, datapath and address width (fixed at 32).
- NUM_REGS, 32, integer register file entries (x0 hardwired to zero).

Ports:
- clock  input  1  core clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- io_imem_req_valid  output  1  instruction fetch request valid
- io_imem_req_bits_addr  output  32  fetch address (= PC_F)
- io_imem_resp_valid  input  1  fetch data valid this cycle
- io_imem_resp_bits_data  input  32  fetched instruction
- io_dmem_req_valid  output  1  data request valid
- io_dmem_req_bits_addr  output  32  data address (rs1+imm)
- io_dmem_req_bits_data  output  32  store data (rs2, unshifted)
- io_dmem_req_bits_fcn  output  1  0 = load, 1 = store
- io_dmem_req_bits_typ  output  3  1=B, 2=H, 3=W, 5=BU, 6=HU, 0 when idle
- io_dmem_resp_valid  input  1  data response / completion
- io_dmem_resp_bits_data  input  32  load data, right-justified by memory
- io_hartid  input  1  unused
- io_interrupt_debug  input  1  used only with the optional feature
- io_interrupt_meip, io_interrupt_msip, io_interrupt_mtip  input  1 each  unused
- io_reset_vector  input  32  boot PC

Behaviour:
- Reset (reset=0), asynchronous:
  - started=0, X valid=0, all register file entries 0.
  - All dmem outputs 0; io_imem_req_valid=0.
  - PC_F is don't-care while started=0.
- Leaving reset:
  - First rising edge with reset=1: PC_F <= io_reset_vector, started <= 1; no instruction is captured.
  - Afterwards io_imem_req_valid=1 constantly.
  - io_imem_req_bits_addr is combinational from PC_F.
- Fetch, each cycle with no stall:
  - io_imem_resp_valid=1: X <= {inst, PC_F, valid=1} and PC_F <= PC_F+4.
  - io_imem_resp_valid=0: X valid <= 0 (bubble) and PC_F holds.
- Execute supports LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP.
  - Shifts use the low 5 bits of the shift amount.
  - Arithmetic is mod 2^32; SLT is signed and SLTU is unsigned.
  - JALR target is (rs1+imm) with bit 0 cleared.
  - Any other opcode (FENCE, SYSTEM, illegal) is a NOP.
- Writeback occurs in X when the instruction completes, unless rd=0. Register reads see the architectural state at the start of X; there are no hazards, since only one instruction is in X.
- Control transfer (taken branch, JAL or JALR) in X:
  - PC_F <= target.
  - The instruction fetched the same cycle is discarded: X valid <= 0.
  - Penalty is 1 cycle. Misaligned targets are not checked.
- Memory operations in X:
  - io_dmem_req_valid=1 with fcn and typ per instruction.
  - The instruction stalls while io_dmem_resp_valid=0. During a stall, PC_F and X hold, fetch data is ignored, and the request stays asserted and stable.
  - Loads complete on io_dmem_resp_valid=1. The result is sign-extended (B, H) or zero-extended (BU, HU) from io_dmem_resp_bits_data; W is taken as-is.
  - Stores complete on io_dmem_resp_valid=1.
- Reset asserted mid-stall clears everything immediately; no partial writeback.

Optional Feature:
- Macro: SODOR2_CORE_DEBUG_HALT_EN.
- Defined:
  - io_interrupt_debug=1 halts fetch: PC_F holds and X receives bubbles.
  - An instruction already in X, including a pending memory operation, completes normally.
  - Deassertion resumes fetch at the held PC_F.
- Undefined: io_interrupt_debug is ignored.

Test Plan:
- Boot: reset_vector=0x00000100, release reset, imem_resp_valid=1 with NOP -> imem_req_bits_addr sequence 0x100, 0x104, 0x108; dmem_req_valid=0.
- ALU: 0x00200313 (addi x6,x0,2) then sw x6,0(x0), resp_valid=1 -> dmem valid=1, fcn=1, typ=3, addr=0, data=2.
- Fetch bubble: imem_resp_valid=0 for 3 cycles -> PC_F constant, no register or memory side effects.
- Branch: x1=x2=5, beq x1,x2,+16 at 0x200 -> next address 0x210; instruction fetched from 0x204 has no effect.
- Load stall and sign-extension: lb with dmem_resp_valid low for 2 cycles, then resp_data=0x00000080 -> PC frozen 2 cycles, rd=0xFFFFFF80; lbu -> 0x00000080.
- Reset mid-stall: drop reset during a pending sw -> dmem_req_valid=0 immediately; reboot from io_reset_vector.
